if_fetch: RTL and testbench

- Instruction-fetch stage. Produces the PC/instruction pair that the IF/ID pipeline register samples.
- Owns the PC, the single-outstanding request/acknowledge handshake to instruction memory, MIPS delay-slot-aware branch redirection, and exception flush.
- While no valid instruction is held, it drives a zero instruction (NOP) and raises a stall request to the pipeline controller. The controller then inserts a bubble into ID.

---
 rtl/if_fetch_pkg.sv | 29 ++
 rtl/if_fetch.sv | 134 +++++++++++++
 tb/tb_if_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, stall
// encodings and the fetch FSM state type.
package if_fetch_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int InstBusW     = 32;
  localparam int InstAddrBusW = 32;
  localparam int StallIfId    = 1;

  typedef logic [InstBusW-1:0]     inst_bus_t;
  typedef logic [InstAddrBusW-1:0] inst_addr_t;

  localparam inst_bus_t ZeroWord = '0;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    REQ     = 2'd1,
    FULL    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

  function automatic inst_addr_t seq_next(input inst_addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, a single-outstanding imem handshake,
// delay-slot-aware branch redirection and exception flush.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  fetch_state_e state_q, state_d;
  inst_addr_t   pc_q, pc_d;
  inst_addr_t   addr_q, addr_d;
  inst_bus_t    inst_buf_q, inst_buf_d;
  logic         pend_valid_q, pend_valid_d;
  inst_addr_t   pend_target_q, pend_target_d;
  logic         req_q, req_d;
  inst_addr_t   if_pc_q, if_pc_d;
  inst_bus_t    if_inst_q, if_inst_d;
  logic         stallreq_q, stallreq_d;

  logic         consume;
  inst_addr_t   next_pc;
  logic         unused_stall;

  assign unused_stall = ^{stall[5:2], stall[0]};

  assign consume = (state_q == FULL) && (stall[StallIfId] == NoStop);
  assign next_pc = branch_flag_i ? branch_target_i :
                   pend_valid_q  ? pend_target_q   : seq_next(pc_q);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_buf_d    = inst_buf_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    if (flush) begin
      pc_d = new_pc;
      if (state_q != DISCARD) begin
        pend_valid_d = 1'b0;
        inst_buf_d   = ZeroWord;
      end
      // A request still on the bus must be drained before the new PC is issued.
      unique case (state_q)
        BOOT, FULL: state_d = REQ;
        REQ:        state_d = imem_ack ? REQ : DISCARD;
        DISCARD:    state_d = imem_ack ? REQ : DISCARD;
        default:    state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        BOOT: state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            inst_buf_d = imem_rdata;
            state_d    = FULL;
          end
        end
        FULL: begin
          if (consume) begin
            pc_d         = next_pc;
            pend_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
        DISCARD: begin
          if (imem_ack) state_d = REQ;
        end
        default: state_d = BOOT;
      endcase
      // The held/in-flight word is the delay slot; remember where to go after it.
      if (branch_flag_i && !consume) begin
        pend_valid_d  = 1'b1;
        pend_target_d = branch_target_i;
      end
    end
  end

  always_comb begin
    addr_d     = (state_d == REQ) ? pc_d : addr_q;
    req_d      = (state_d == REQ) || (state_d == DISCARD);
    stallreq_d = (state_d != FULL);
    if_pc_d    = (state_d == FULL) ? pc_d : '0;
    if_inst_d  = (state_d == FULL) ? inst_buf_d : ZeroWord;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      addr_q        <= RESET_PC;
      inst_buf_q    <= ZeroWord;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      req_q         <= 1'b0;
      if_pc_q       <= '0;
      if_inst_q     <= ZeroWord;
      stallreq_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      inst_buf_q    <= inst_buf_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      req_q         <= req_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
      stallreq_q    <= stallreq_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign if_pc       = if_pc_q;
  assign if_inst     = if_inst_q;
  assign stallreq_if = stallreq_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: latency-programmable memory model with
// request/delivery scoreboards, a vector table and hand-written redirect cases.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush           (flush),
    .new_pc          (new_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .stallreq_if     (stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          stops;
    logic [31:0] addr;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cnt = 0;
  int          delivered = 0;
  logic        prev_req = 1'b0;
  logic        prev_stallreq = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], 16'hC0DE} ^ 32'h1234_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: sample DUT after the edge, score it, then drive memory for the next edge.
  task automatic tick();
    logic        edge_ack;
    logic [31:0] e;
    @(posedge clk);
    #1;
    edge_ack = imem_ack;
    if (imem_req && (!prev_req || edge_ack)) begin
      $display("request addr=%h", imem_addr);
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request actual=%h expected=none", imem_addr);
      end else begin
        e = exp_addr.pop_front();
        check32("req_addr", imem_addr, e);
      end
    end else if (imem_req) begin
      check32("addr_hold", imem_addr, prev_addr);
    end
    if (prev_stallreq && !stallreq_if) begin
      delivered++;
      $display("deliver pc=%h inst=%h", if_pc, if_inst);
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery actual=%h expected=none", if_pc);
      end else begin
        e = exp_pc.pop_front();
        check32("if_pc", if_pc, e);
        check32("if_inst", if_inst, memf(e));
      end
    end
    if (stallreq_if) begin
      check32("bubble_inst", if_inst, 32'h0);
      check32("bubble_pc", if_pc, 32'h0);
    end
    if (edge_ack) cnt = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    if (imem_req) begin
      cnt++;
      if (cnt > lat) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
      end
    end
    prev_req      = imem_req;
    prev_addr     = imem_addr;
    prev_stallreq = stallreq_if;
  endtask

  task automatic wait_deliver(input string name, output int n);
    int start;
    start = delivered;
    n = 0;
    while (delivered == start && n < 60) begin
      tick();
      n++;
    end
    if (delivered == start) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d cycles expected=delivery", name, n);
    end
  endtask

  initial begin
    vec_t vt[4];
    int   n;

    vt[0] = '{lat: 1, stops: 0, addr: 32'h0000_0000};
    vt[1] = '{lat: 1, stops: 0, addr: 32'h0000_0004};
    vt[2] = '{lat: 5, stops: 0, addr: 32'h0000_0008};
    vt[3] = '{lat: 1, stops: 3, addr: 32'h0000_000C};

    rst             = 1'b1;
    stall           = 6'b0;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
    flush           = 1'b0;
    new_pc          = 32'h0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;

    repeat (3) tick();
    check32("rst_req", 32'(imem_req), 32'h0);
    check32("rst_stallreq", 32'(stallreq_if), 32'h0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_inst", if_inst, 32'h0);
    rst = 1'b0;

    // Sequential fetch under varying latency and IF/ID hold.
    for (int i = 0; i < 4; i++) begin
      lat = vt[i].lat;
      exp_addr.push_back(vt[i].addr);
      exp_pc.push_back(vt[i].addr);
      wait_deliver("vec", n);
      check32("vec_cycles", n, vt[i].lat + 2);
      if (vt[i].stops > 0) begin
        stall[1] = 1'b1;
        for (int j = 0; j < vt[i].stops; j++) begin
          tick();
          check32("hold_pc", if_pc, vt[i].addr);
          check32("hold_inst", if_inst, memf(vt[i].addr));
          check32("hold_req", 32'(imem_req), 32'h0);
          check32("hold_stallreq", 32'(stallreq_if), 32'h0);
        end
        stall[1] = 1'b0;
      end
    end

    // Branch resolved while the delay slot is in flight; second branch overwrites.
    lat = 1;
    exp_addr.push_back(32'h10);
    exp_pc.push_back(32'h10);
    wait_deliver("seq_10", n);
    lat = 3;
    exp_addr.push_back(32'h14);
    exp_pc.push_back(32'h14);
    tick();
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hF0;
    tick();
    branch_target_i = 32'h100;
    tick();
    branch_flag_i = 1'b0;
    exp_addr.push_back(32'h100);
    exp_pc.push_back(32'h100);
    wait_deliver("delay_slot", n);
    wait_deliver("branch_target", n);

    // Branch taken in the cycle the held delay slot is consumed.
    lat = 1;
    exp_addr.push_back(32'h200);
    exp_pc.push_back(32'h200);
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h200;
    tick();
    branch_flag_i = 1'b0;
    wait_deliver("branch_on_consume", n);

    // Flush while a request is outstanding: old data must be drained and dropped.
    lat = 3;
    exp_addr.push_back(32'h204);
    tick();
    flush  = 1'b1;
    new_pc = 32'h180;
    exp_addr.push_back(32'h180);
    exp_pc.push_back(32'h180);
    tick();
    flush = 1'b0;
    check32("discard_req", 32'(imem_req), 32'h1);
    check32("discard_addr", imem_addr, 32'h204);
    wait_deliver("flush_target", n);

    // Flush, branch and ack in the same cycle: flush wins, ack data dropped.
    lat = 1;
    exp_addr.push_back(32'h184);
    tick();
    tick();
    flush           = 1'b1;
    new_pc          = 32'h2C0;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'h400;
    exp_addr.push_back(32'h2C0);
    exp_pc.push_back(32'h2C0);
    tick();
    flush         = 1'b0;
    branch_flag_i = 1'b0;
    wait_deliver("flush_ack", n);
    exp_addr.push_back(32'h2C4);
    exp_pc.push_back(32'h2C4);
    wait_deliver("after_flush_seq", n);

    check32("addr_queue_left", exp_addr.size(), 32'h0);
    check32("pc_queue_left", exp_pc.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
